tx_frame_arbiter: RTL and testbench

TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

---
 rtl/tx_frame_arbiter.sv | 121 ++++++++++++
 tb/tb_tx_frame_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter that takes single-byte RF frames and two-byte ALU frames
// and writes them byte by byte into a FIFO write port. ALU frames are never split.
module tx_frame_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  input  logic                      rf_valid,
  output logic                      rf_ready,
  input  logic [2*DATA_WIDTH-1:0]   alu_data,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic                      full,
  output logic [DATA_WIDTH-1:0]     WR_data,
  output logic                      winc,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RF_WR  = 2'd1,
    ALU_LO = 2'd2,
    ALU_HI = 2'd3
  } state_t;

  localparam logic GRANT_RF  = 1'b0;
  localparam logic GRANT_ALU = 1'b1;

  state_t                    r_state;
  state_t                    w_next_state;
  logic                      r_last_grant;
  logic [DATA_WIDTH-1:0]     r_rf_hold;
  logic [2*DATA_WIDTH-1:0]   r_alu_hold;
  logic                      w_rf_acc;
  logic                      w_alu_acc;

  assign w_rf_acc  = rf_valid & rf_ready;
  assign w_alu_acc = alu_valid & alu_ready;
  assign busy      = (r_state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture accepted frames and remember who was served last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_hold    <= '0;
      r_alu_hold   <= '0;
      r_last_grant <= GRANT_ALU;
    end else if (w_rf_acc) begin
      r_rf_hold    <= rf_data;
      r_last_grant <= GRANT_RF;
    end else if (w_alu_acc) begin
      r_alu_hold   <= alu_data;
      r_last_grant <= GRANT_ALU;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  // Arbitration, write strobe, byte mux and next state
  always_comb begin
    w_next_state = r_state;
    rf_ready     = 1'b0;
    alu_ready    = 1'b0;
    winc         = 1'b0;
    WR_data      = '0;
    case (r_state)
      IDLE: begin
        // Readies are gated by rst_n so nothing looks accepted while in reset
        if (rst_n && rf_valid && (!alu_valid || (r_last_grant == GRANT_ALU))) begin
          rf_ready     = 1'b1;
          w_next_state = RF_WR;
        end else if (rst_n && alu_valid) begin
          alu_ready    = 1'b1;
          w_next_state = ALU_LO;
        end else begin
          w_next_state = IDLE;
        end
      end
      RF_WR: begin
        WR_data = r_rf_hold;
        winc    = ~full;
        if (!full) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = RF_WR;
        end
      end
      ALU_LO: begin
        WR_data = r_alu_hold[DATA_WIDTH-1:0];
        winc    = ~full;
        if (!full) begin
          w_next_state = ALU_HI;
        end else begin
          w_next_state = ALU_LO;
        end
      end
      ALU_HI: begin
        WR_data = r_alu_hold[2*DATA_WIDTH-1:DATA_WIDTH];
        winc    = ~full;
        if (!full) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = ALU_HI;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench: directed vector table, reset corner cases and a random
// run against a byte-queue reference model of the arbiter.
module tb_tx_frame_arbiter;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rf_data;
  logic        rf_valid;
  logic        rf_ready;
  logic [15:0] alu_data;
  logic        alu_valid;
  logic        alu_ready;
  logic        full;
  logic [7:0]  WR_data;
  logic        winc;
  logic        busy;

  tx_frame_arbiter #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rf_data(rf_data), .rf_valid(rf_valid), .rf_ready(rf_ready),
    .alu_data(alu_data), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .full(full), .WR_data(WR_data), .winc(winc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [7:0]  rd;
    logic        av;
    logic [15:0] ad;
    logic        f;
    logic        e_rr;
    logic        e_ar;
    logic        e_w;
    logic [7:0]  e_d;
    logic        e_b;
  } vec_t;

  vec_t tab[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: bytes still owed to the FIFO, and who was served last
  logic [7:0]  mq[$];
  logic        m_lg;
  logic        e_rf, e_alu, e_winc, e_busy;
  logic [7:0]  e_wr;
  logic [7:0]  cur_rd;
  logic [15:0] cur_ad;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic rv, input logic [7:0] rd, input logic av, input logic [15:0] ad,
                     input logic f, input logic err, input logic ear, input logic ew,
                     input logic [7:0] ed, input logic eb);
    vec_t v;
    v.rv = rv; v.rd = rd; v.av = av; v.ad = ad; v.f = f;
    v.e_rr = err; v.e_ar = ear; v.e_w = ew; v.e_d = ed; v.e_b = eb;
    tab.push_back(v);
  endtask

  task automatic model_reset();
    mq.delete();
    m_lg = 1'b1;
  endtask

  task automatic apply(input logic rv, input logic [7:0] rd, input logic av, input logic [15:0] ad, input logic f);
    rf_valid = rv; rf_data = rd; alu_valid = av; alu_data = ad; full = f;
    cur_rd = rd; cur_ad = ad;
    #2;
    e_rf   = (mq.size() == 0) && rv && (!av || m_lg);
    e_alu  = (mq.size() == 0) && av && !e_rf;
    e_winc = (mq.size() != 0) && !f;
    e_wr   = (mq.size() != 0) ? mq[0] : 8'h00;
    e_busy = (mq.size() != 0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rf_ready"},  {15'd0, rf_ready},  {15'd0, e_rf});
    chk({tag, ".alu_ready"}, {15'd0, alu_ready}, {15'd0, e_alu});
    chk({tag, ".winc"},      {15'd0, winc},      {15'd0, e_winc});
    chk({tag, ".WR_data"},   {8'd0, WR_data},    {8'd0, e_wr});
    chk({tag, ".busy"},      {15'd0, busy},      {15'd0, e_busy});
  endtask

  task automatic advance();
    logic [7:0] tmp;
    @(posedge clk);
    if (e_winc) tmp = mq.pop_front();
    if (e_rf) begin
      mq.push_back(cur_rd);
      m_lg = 1'b0;
    end
    if (e_alu) begin
      mq.push_back(cur_ad[7:0]);
      mq.push_back(cur_ad[15:8]);
      m_lg = 1'b1;
    end
    #1;
  endtask

  logic        rp, ap, fr;
  logic [7:0]  rdv;
  logic [15:0] adv;

  initial begin
    rst_n = 1'b0; rf_valid = 1'b1; rf_data = 8'hA5; alu_valid = 1'b1; alu_data = 16'h1234; full = 1'b0;
    model_reset();
    #2;
    chk("rst.rf_ready", {15'd0, rf_ready}, 16'd0);
    chk("rst.alu_ready", {15'd0, alu_ready}, 16'd0);
    chk("rst.winc", {15'd0, winc}, 16'd0);
    chk("rst.WR_data", {8'd0, WR_data}, 16'd0);
    chk("rst.busy", {15'd0, busy}, 16'd0);
    rf_valid = 1'b0; alu_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    //    rv    rd     av    ad        f     rr    ar    w     d      b
    add(1'b1, 8'hA5, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1);
    add(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 8'h34, 1'b1);
    add(1'b0, 8'h00, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b1);
    add(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h34, 1'b1);
    add(1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1);
    add(1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1);
    add(1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1);
    add(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b1);
    add(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'h5A, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1);
    add(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
    add(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'h11, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'h11, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b1, 8'hCD, 1'b1);
    add(1'b1, 8'h11, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAB, 1'b1);
    add(1'b1, 8'h11, 1'b1, 16'hABCD, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1);
    add(1'b0, 8'h00, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b0, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b1, 8'hCD, 1'b1);
    add(1'b0, 8'h00, 1'b0, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAB, 1'b1);
    add(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    foreach (tab[i]) begin
      apply(tab[i].rv, tab[i].rd, tab[i].av, tab[i].ad, tab[i].f);
      chk($sformatf("vec%0d.rf_ready", i),  {15'd0, rf_ready},  {15'd0, tab[i].e_rr});
      chk($sformatf("vec%0d.alu_ready", i), {15'd0, alu_ready}, {15'd0, tab[i].e_ar});
      chk($sformatf("vec%0d.winc", i),      {15'd0, winc},      {15'd0, tab[i].e_w});
      chk($sformatf("vec%0d.WR_data", i),   {8'd0, WR_data},    {8'd0, tab[i].e_d});
      chk($sformatf("vec%0d.busy", i),      {15'd0, busy},      {15'd0, tab[i].e_b});
      advance();
    end

    // Reset while the ALU high byte is still pending
    apply(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0); check_model("abort.acc"); advance();
    apply(1'b0, 8'h00, 1'b0, 16'h1234, 1'b0); check_model("abort.lo");  advance();
    apply(1'b0, 8'h00, 1'b0, 16'h1234, 1'b0);
    chk("abort.pre_hi_busy", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.winc", {15'd0, winc}, 16'd0);
    chk("abort.busy", {15'd0, busy}, 16'd0);
    chk("abort.WR_data", {8'd0, WR_data}, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 8'h00, 1'b0, 16'h1234, 1'b0); check_model("abort.after"); advance();
    end
    // First tie after reset goes to RF
    apply(1'b1, 8'h77, 1'b1, 16'h9988, 1'b0);
    chk("tie_after_reset.rf_ready", {15'd0, rf_ready}, 16'd1);
    check_model("tie_after_reset");
    advance();

    rp = 1'b0; ap = 1'b0; rdv = 8'h77; adv = 16'h9988;
    for (int n = 0; n < 3000; n++) begin
      if (!rp && $urandom_range(0, 2) == 0) begin rp = 1'b1; rdv = 8'($urandom); end
      if (!ap && $urandom_range(0, 2) == 0) begin ap = 1'b1; adv = 16'($urandom); end
      if (rp && $urandom_range(0, 15) == 0) rp = 1'b0;
      fr = ($urandom_range(0, 3) == 0);
      apply(rp, rdv, ap, adv, fr);
      check_model("rand");
      advance();
      if (e_rf) rp = 1'b0;
      if (e_alu) ap = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
